hdd_sd_sequencer: RTL and testbench

- Sequences ProDOS HDD block transfers between the HDD card's 512-byte sector buffer and the MiSTer SD block-device channel (sd_lba/sd_rd/sd_wr/sd_ack).
- Converts the card's one-cycle hdd_read/hdd_write strobes into a full SD request/acknowledge handshake.
- Routes sd_buff traffic onto the card's ram_* port and holds the 6502 halted until the transfer completes or times out.
- Sits between hdd and the top-level sd_* wiring.

---
 rtl/hdd_sd_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_hdd_sd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdd_sd_sequencer.sv
// hdd_sd_sequencer: bridges the ProDOS HDD card's single-cycle block strobes
// onto the MiSTer SD block-device request/acknowledge channel, steering the
// host's sd_buff byte traffic into the card's 512-byte sector buffer and
// holding the 6502 until each transfer completes or is abandoned.
//
// SD channel handshake: a request (sd_rd or sd_wr) is raised together with a
// stable sd_lba and held until the host answers with sd_ack=1; the request is
// dropped on that same edge. sd_ack then stays high for the entire data phase
// and its fall marks the end of the block. A request that is not answered,
// or a data phase that never ends, is abandoned after TIMEOUT cycles and the
// sticky error flag is raised.
module hdd_sd_sequencer #(
    parameter logic [31:0] LBA_BASE = 32'd0,
    parameter logic [23:0] TIMEOUT  = 24'd14000000
) (
    input  logic        CLK_14M,
    input  logic        RESET_N,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic [15:0] sector,
    input  logic        hdd_mounted,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [8:0]  ram_addr,
    output logic [7:0]  ram_di,
    output logic        ram_we,
    input  logic [7:0]  ram_do,
    output logic        cpu_halt,
    output logic        busy,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operation encoding: 0 = read (SD -> sector buffer), 1 = write.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    state_t      state;
    logic        op;
    logic [23:0] count;
    logic        aborted;

    // Single-entry pending slot for strobes that arrive while busy.
    logic        pend_valid;
    logic        pend_op;
    logic [15:0] pend_sector;

    // Launch / store decisions shared by the FSM and the pending slot.
    logic        strobe;
    logic        timeout_hit;
    logic        launch;
    logic        launch_from_pend;
    logic        launch_op;
    logic [15:0] launch_sector;
    logic        store;
    logic        store_op;

    assign strobe      = hdd_mounted & (hdd_read | hdd_write);
    assign timeout_hit = (count == (TIMEOUT - 24'd1));

    // Decide whether this edge starts a transfer and whether a strobe must be parked.
    always_comb begin
        launch           = 1'b0;
        launch_from_pend = 1'b0;
        launch_op        = hdd_read ? OP_READ : OP_WRITE;
        launch_sector    = sector;
        store            = 1'b0;
        // When parking, a write wins over a read arriving in the same cycle
        // since the read is the one serviced directly when idle.
        store_op         = hdd_write ? OP_WRITE : OP_READ;
        case (state)
            IDLE: begin
                if (strobe) begin
                    launch   = 1'b1;
                    store    = hdd_read & hdd_write;
                    store_op = OP_WRITE;
                end
            end
            REQ, XFER: begin
                store = strobe;
            end
            DONE: begin
                if (pend_valid) begin
                    launch           = 1'b1;
                    launch_from_pend = 1'b1;
                    launch_op        = pend_op;
                    launch_sector    = pend_sector;
                    store            = strobe;
                end else if (strobe) begin
                    launch   = 1'b1;
                    store    = hdd_read & hdd_write;
                    store_op = OP_WRITE;
                end
            end
            default: begin
                launch = 1'b0;
            end
        endcase
    end

    // Pending slot: latest strobe wins; emptied when its transfer is launched.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_valid  <= 1'b0;
            pend_op     <= OP_READ;
            pend_sector <= 16'h0000;
        end else if (store) begin
            pend_valid  <= 1'b1;
            pend_op     <= store_op;
            pend_sector <= sector;
        end else if (launch_from_pend) begin
            pend_valid  <= 1'b0;
        end
    end

    // Transfer sequencer: request, data phase, completion, with timeout abort.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            op       <= OP_READ;
            sd_lba   <= 32'h0000_0000;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            cpu_halt <= 1'b0;
            error    <= 1'b0;
            count    <= 24'd0;
            aborted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                REQ: begin
                    if (timeout_hit) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        error   <= 1'b1;
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count + 24'd1;
                        if (sd_ack) begin
                            sd_rd <= 1'b0;
                            sd_wr <= 1'b0;
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (timeout_hit) begin
                        error   <= 1'b1;
                        aborted <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count + 24'd1;
                        if (!sd_ack) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!aborted) begin
                        error <= 1'b0;
                    end
                    cpu_halt <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A launch overrides the idle/return path above; cpu_halt stays
            // high straight through a back-to-back DONE -> REQ hand-off.
            if (launch) begin
                op       <= launch_op;
                sd_lba   <= LBA_BASE + {16'h0000, launch_sector};
                sd_rd    <= (launch_op == OP_READ);
                sd_wr    <= (launch_op == OP_WRITE);
                cpu_halt <= 1'b1;
                count    <= 24'd0;
                aborted  <= 1'b0;
                state    <= REQ;
            end
        end
    end

    // Byte path between host buffer port and sector buffer; only host writes
    // belonging to a read operation may land in the sector buffer.
    always_comb begin
        ram_addr    = sd_buff_addr;
        ram_di      = sd_buff_dout;
        sd_buff_din = ram_do;
        ram_we      = (state == XFER) & sd_buff_wr & sd_ack & (op == OP_READ);
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hdd_sd_sequencer.sv
// tb_hdd_sd_sequencer: directed bench for hdd_sd_sequencer. Instance u_a uses
// LBA_BASE=0 with a timeout long enough for full 512-byte blocks; instance
// u_b uses LBA_BASE=32'hFFFF_0001 and TIMEOUT=16 for the wrap and timeout
// cases. Both share clock, reset and the host byte port; each has its own
// strobes and acknowledge.
module tb_hdd_sd_sequencer;

    logic        CLK_14M;
    logic        RESET_N;
    logic [15:0] sector;
    logic        hdd_mounted;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  ram_do;

    logic        a_read, a_write, a_ack;
    logic [31:0] a_sd_lba;
    logic        a_sd_rd, a_sd_wr;
    logic [7:0]  a_sd_buff_din;
    logic [8:0]  a_ram_addr;
    logic [7:0]  a_ram_di;
    logic        a_ram_we, a_cpu_halt, a_busy, a_error;

    logic        b_read, b_write, b_ack;
    logic [31:0] b_sd_lba;
    logic        b_sd_rd, b_sd_wr;
    logic [7:0]  b_sd_buff_din;
    logic [8:0]  b_ram_addr;
    logic [7:0]  b_ram_di;
    logic        b_ram_we, b_cpu_halt, b_busy, b_error;

    int checks;
    int errors;
    int we_seen;

    hdd_sd_sequencer #(.LBA_BASE(32'd0), .TIMEOUT(24'd1000)) u_a (
        .CLK_14M(CLK_14M), .RESET_N(RESET_N),
        .hdd_read(a_read), .hdd_write(a_write), .sector(sector),
        .hdd_mounted(hdd_mounted),
        .sd_lba(a_sd_lba), .sd_rd(a_sd_rd), .sd_wr(a_sd_wr), .sd_ack(a_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(a_sd_buff_din),
        .ram_addr(a_ram_addr), .ram_di(a_ram_di), .ram_we(a_ram_we),
        .ram_do(ram_do),
        .cpu_halt(a_cpu_halt), .busy(a_busy), .error(a_error)
    );

    hdd_sd_sequencer #(.LBA_BASE(32'hFFFF_0001), .TIMEOUT(24'd16)) u_b (
        .CLK_14M(CLK_14M), .RESET_N(RESET_N),
        .hdd_read(b_read), .hdd_write(b_write), .sector(sector),
        .hdd_mounted(hdd_mounted),
        .sd_lba(b_sd_lba), .sd_rd(b_sd_rd), .sd_wr(b_sd_wr), .sd_ack(b_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(b_sd_buff_din),
        .ram_addr(b_ram_addr), .ram_di(b_ram_di), .ram_we(b_ram_we),
        .ram_do(ram_do),
        .cpu_halt(b_cpu_halt), .busy(b_busy), .error(b_error)
    );

    // Clock: 10 ns period.
    initial begin
        CLK_14M = 1'b0;
        forever #5 CLK_14M = ~CLK_14M;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK_14M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        we_seen      = 0;
        RESET_N      = 1'b0;
        sector       = 16'h0000;
        hdd_mounted  = 1'b1;
        sd_buff_addr = 9'd0;
        sd_buff_dout = 8'd0;
        sd_buff_wr   = 1'b0;
        ram_do       = 8'd0;
        a_read = 1'b0; a_write = 1'b0; a_ack = 1'b0;
        b_read = 1'b0; b_write = 1'b0; b_ack = 1'b0;

        // Reset state
        step(); step(); step();
        check("rst_lba", a_sd_lba, 32'h0);
        check("rst_rd", {31'd0, a_sd_rd}, 32'd0);
        check("rst_wr", {31'd0, a_sd_wr}, 32'd0);
        check("rst_halt", {31'd0, a_cpu_halt}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_error", {31'd0, a_error}, 32'd0);
        RESET_N = 1'b1;
        step();

        // Read of block 0x12 with a full 512-byte host write burst
        sector = 16'h0012; a_read = 1'b1;
        step();
        a_read = 1'b0;
        check("rd_req_rd", {31'd0, a_sd_rd}, 32'd1);
        check("rd_req_wr", {31'd0, a_sd_wr}, 32'd0);
        check("rd_req_lba", a_sd_lba, 32'h0000_0012);
        check("rd_req_halt", {31'd0, a_cpu_halt}, 32'd1);
        check("rd_req_busy", {31'd0, a_busy}, 32'd1);
        a_ack = 1'b1;
        step();
        check("rd_ack_drop", {31'd0, a_sd_rd}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i);
            sd_buff_wr   = 1'b1;
            #1;
            check("rd_we", {31'd0, a_ram_we}, 32'd1);
            check("rd_addr", {23'd0, a_ram_addr}, 32'(i));
            check("rd_di", {24'd0, a_ram_di}, 32'(i % 256));
            if (a_ram_we) we_seen++;
            step();
        end
        sd_buff_wr = 1'b0;
        #1;
        check("rd_we_idle", {31'd0, a_ram_we}, 32'd0);
        check("rd_we_count", 32'(we_seen), 32'd512);
        a_ack = 1'b0;
        step();
        check("rd_done_halt", {31'd0, a_cpu_halt}, 32'd1);
        check("rd_done_busy", {31'd0, a_busy}, 32'd1);
        step();
        check("rd_end_halt", {31'd0, a_cpu_halt}, 32'd0);
        check("rd_end_busy", {31'd0, a_busy}, 32'd0);
        check("rd_end_error", {31'd0, a_error}, 32'd0);

        // Write of block 0xFFFF on u_b: lba wraps to 0, host writes blocked
        sector = 16'hFFFF; b_write = 1'b1;
        step();
        b_write = 1'b0;
        check("wr_req_wr", {31'd0, b_sd_wr}, 32'd1);
        check("wr_req_rd", {31'd0, b_sd_rd}, 32'd0);
        check("wr_wrap_lba", b_sd_lba, 32'h0000_0000);
        check("wr_req_halt", {31'd0, b_cpu_halt}, 32'd1);
        b_ack = 1'b1;
        step();
        check("wr_ack_drop", {31'd0, b_sd_wr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            sd_buff_addr = 9'(i * 37 + 100);
            ram_do       = 8'(8'hA0 + i);
            sd_buff_dout = 8'h55;
            sd_buff_wr   = 1'b1;
            #1;
            check("wr_din", {24'd0, b_sd_buff_din}, 32'(8'hA0 + i));
            check("wr_no_we", {31'd0, b_ram_we}, 32'd0);
            check("wr_addr", {23'd0, b_ram_addr}, 32'(i * 37 + 100));
            step();
        end
        sd_buff_wr = 1'b0;
        b_ack = 1'b0;
        step();
        check("wr_done_halt", {31'd0, b_cpu_halt}, 32'd1);
        step();
        check("wr_end_halt", {31'd0, b_cpu_halt}, 32'd0);
        check("wr_end_busy", {31'd0, b_busy}, 32'd0);
        check("wr_end_error", {31'd0, b_error}, 32'd0);

        // Timeout on u_b (TIMEOUT=16): request held exactly 16 cycles
        sector = 16'h0009; b_read = 1'b1;
        step();
        b_read = 1'b0;
        check("to_req_rd", {31'd0, b_sd_rd}, 32'd1);
        check("to_req_lba", b_sd_lba, 32'hFFFF_000A);
        for (int i = 0; i < 15; i++) step();
        check("to_still_rd", {31'd0, b_sd_rd}, 32'd1);
        check("to_still_err", {31'd0, b_error}, 32'd0);
        step();
        check("to_drop_rd", {31'd0, b_sd_rd}, 32'd0);
        check("to_error", {31'd0, b_error}, 32'd1);
        check("to_done_halt", {31'd0, b_cpu_halt}, 32'd1);
        step();
        check("to_end_halt", {31'd0, b_cpu_halt}, 32'd0);
        check("to_end_busy", {31'd0, b_busy}, 32'd0);
        check("to_sticky", {31'd0, b_error}, 32'd1);
        sector = 16'h0001; b_read = 1'b1;
        step();
        b_read = 1'b0;
        check("to_next_rd", {31'd0, b_sd_rd}, 32'd1);
        check("to_next_err", {31'd0, b_error}, 32'd1);
        b_ack = 1'b1;
        step();
        b_ack = 1'b0;
        step();
        step();
        check("to_clear_err", {31'd0, b_error}, 32'd0);
        check("to_clear_halt", {31'd0, b_cpu_halt}, 32'd0);

        // Pending: write of block 5 arrives while read of block 3 is in XFER
        sector = 16'h0003; a_read = 1'b1;
        step();
        a_read = 1'b0;
        check("pd_rd_lba", a_sd_lba, 32'h0000_0003);
        a_ack = 1'b1;
        step();
        sector = 16'h0005; a_write = 1'b1;
        step();
        a_write = 1'b0;
        check("pd_xfer_halt", {31'd0, a_cpu_halt}, 32'd1);
        step();
        a_ack = 1'b0;
        step();
        check("pd_done_halt", {31'd0, a_cpu_halt}, 32'd1);
        check("pd_done_wr", {31'd0, a_sd_wr}, 32'd0);
        step();
        check("pd_launch_wr", {31'd0, a_sd_wr}, 32'd1);
        check("pd_launch_lba", a_sd_lba, 32'h0000_0005);
        check("pd_launch_halt", {31'd0, a_cpu_halt}, 32'd1);
        check("pd_launch_busy", {31'd0, a_busy}, 32'd1);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        step();
        step();
        check("pd_end_halt", {31'd0, a_cpu_halt}, 32'd0);
        check("pd_end_busy", {31'd0, a_busy}, 32'd0);

        // Simultaneous read and write strobes on block 7
        sector = 16'h0007; a_read = 1'b1; a_write = 1'b1;
        step();
        a_read = 1'b0; a_write = 1'b0;
        check("sim_rd_first", {31'd0, a_sd_rd}, 32'd1);
        check("sim_wr_later", {31'd0, a_sd_wr}, 32'd0);
        check("sim_rd_lba", a_sd_lba, 32'h0000_0007);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        step();
        step();
        check("sim_wr_next", {31'd0, a_sd_wr}, 32'd1);
        check("sim_rd_off", {31'd0, a_sd_rd}, 32'd0);
        check("sim_wr_lba", a_sd_lba, 32'h0000_0007);
        check("sim_halt_held", {31'd0, a_cpu_halt}, 32'd1);
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        step();
        step();
        check("sim_end_busy", {31'd0, a_busy}, 32'd0);
        check("sim_end_halt", {31'd0, a_cpu_halt}, 32'd0);

        // Reset mid-REQ drops outputs without a clock edge
        sector = 16'h0002; a_read = 1'b1;
        step();
        a_read = 1'b0;
        check("rq_rd_before", {31'd0, a_sd_rd}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("rq_rd_async", {31'd0, a_sd_rd}, 32'd0);
        check("rq_halt_async", {31'd0, a_cpu_halt}, 32'd0);
        check("rq_busy_async", {31'd0, a_busy}, 32'd0);
        RESET_N = 1'b1;
        step();
        a_ack = 1'b1; sd_buff_wr = 1'b1; sd_buff_addr = 9'd33;
        #1;
        check("stray_no_we", {31'd0, a_ram_we}, 32'd0);
        step();
        check("stray_idle", {31'd0, a_busy}, 32'd0);
        check("stray_no_rd", {31'd0, a_sd_rd}, 32'd0);
        a_ack = 1'b0; sd_buff_wr = 1'b0;
        step();

        // Strobe with no image mounted is ignored
        hdd_mounted = 1'b0; a_read = 1'b1;
        step();
        a_read = 1'b0;
        check("unmnt_busy", {31'd0, a_busy}, 32'd0);
        check("unmnt_rd", {31'd0, a_sd_rd}, 32'd0);
        hdd_mounted = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
